// File: rtl/btn_cond_pkg.sv
// Shared power-control definitions: debounce FSM encoding and default timing constants.
// The power sequencer imports the same package, so both blocks agree on the encoding.
package btn_cond_pkg;

   typedef enum logic [1:0] {
      REL    = 2'd0,
      P_WAIT = 2'd1,
      PRS    = 2'd2,
      R_WAIT = 2'd3
   } btn_state_t;

   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DB_CYCLES   = 65535;
   localparam int DEF_LONG_CYCLES = 1000000;

endpackage

// File: rtl/btn_cond_sync_ff.sv
// Parameterised-depth synchroniser for asynchronous pads; the chain resets to 0.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= '0;
      else        chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_cond.sv
// LCD power push-button conditioner: synchronise, debounce, and emit a clean level
// plus single-cycle press / release / long-press pulses (all registered).
module btn_cond
   import btn_cond_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int DB_CYCLES      = DEF_DB_CYCLES,
   parameter int LONG_CYCLES    = DEF_LONG_CYCLES,
   parameter int BTN_ACTIVE_LOW = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn,
   output logic press,
   output logic release_pulse,
   output logic long_press
);

   localparam int DBW = $clog2(DB_CYCLES + 1);
   localparam int HW  = $clog2(LONG_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_MAX  = HW'(LONG_CYCLES);

   logic           pad_pressed;
   logic           btn_s;
   btn_state_t     state;
   logic [DBW-1:0] db_cnt;
   logic [HW-1:0]  hold_cnt;

   assign pad_pressed = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad_pressed),
      .q     (btn_s)
   );

   // Acceptance happens on the edge that would bring db_cnt to DB_CYCLES, hence DB_LAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= REL;
         db_cnt        <= '0;
         hold_cnt      <= '0;
         btn           <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         press         <= 1'b0;
         release_pulse <= 1'b0;
         long_press    <= 1'b0;
         unique case (state)
            REL: begin
               db_cnt <= '0;
               if (btn_s) state <= P_WAIT;
            end
            P_WAIT: begin
               if (!btn_s) begin
                  state  <= REL;
                  db_cnt <= '0;
               end else if (db_cnt == DB_LAST) begin
                  state    <= PRS;
                  db_cnt   <= '0;
                  btn      <= 1'b1;
                  press    <= 1'b1;
                  hold_cnt <= '0;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            PRS: begin
               // The exit edge into R_WAIT still counts as a PRS cycle for the hold timer.
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt   <= HOLD_MAX;
                  long_press <= 1'b1;
               end else if (hold_cnt != HOLD_MAX) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
               if (!btn_s) begin
                  state  <= R_WAIT;
                  db_cnt <= '0;
               end
            end
            R_WAIT: begin
               if (btn_s) begin
                  state <= PRS;
               end else if (db_cnt == DB_LAST) begin
                  state         <= REL;
                  db_cnt        <= '0;
                  btn           <= 1'b0;
                  release_pulse <= 1'b1;
                  hold_cnt      <= '0;
               end else begin
                  db_cnt <= db_cnt + 1'b1;
               end
            end
            default: state <= REL;
         endcase
      end
   end

endmodule
